// File: rtl/load_scoreboard_if.sv
// Decode-side handshake between the decode stage and the load scoreboard:
// the instruction being offered for issue, the load writeback port, and
// the stall/fire answer returned to decode.
interface load_scoreboard_if;
    logic       flush;
    logic       issue_valid;
    logic       issue_uses_rs1;
    logic       issue_uses_rs2;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic [4:0] issue_rd;
    logic       issue_is_reg_write;
    logic       issue_is_load;
    logic       wb_valid;
    logic [4:0] wb_reg;
    logic       issue_stall;
    logic       issue_fire;

    // Decode side: offers instructions and load writebacks, receives the verdict.
    modport master (
        output flush, issue_valid, issue_uses_rs1, issue_uses_rs2,
               issue_rs1, issue_rs2, issue_rd, issue_is_reg_write,
               issue_is_load, wb_valid, wb_reg,
        input  issue_stall, issue_fire
    );

    // Scoreboard side.
    modport slave (
        input  flush, issue_valid, issue_uses_rs1, issue_uses_rs2,
               issue_rs1, issue_rs2, issue_rd, issue_is_reg_write,
               issue_is_load, wb_valid, wb_reg,
        output issue_stall, issue_fire
    );
endinterface

// File: rtl/load_scoreboard.sv
// Load scoreboard: remembers the destination registers of loads that have
// left decode but not yet written back, and stalls decode on RAW/WAW hazards
// against them or when the pending table is full. A writeback arriving in the
// same cycle as the hazard check is treated as already resolved, since the
// writeback bypass supplies that data.
module load_scoreboard #(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk,
    input  logic               rst,
    load_scoreboard_if.slave   sb,
    output logic [31:0]        pending_mask,
    output logic [CNT_W-1:0]   outstanding
);

    logic [31:0]      pending_q,     pending_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    logic [31:0]      eff_pending;
    logic [CNT_W-1:0] outstanding_after_wb;
    logic             wb_clear;
    logic             raw1, raw2, waw, full;
    logic             is_tracked_load;
    logic             stall;
    logic             fire;
    logic             set;

    // Hazard evaluation against the pending table as seen after this cycle's writeback.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update so no latch is inferred.
        wb_clear = sb.wb_valid && (sb.wb_reg != 5'd0) && pending_q[sb.wb_reg];

        eff_pending = pending_q;
        if (wb_clear) begin
            eff_pending[sb.wb_reg] = 1'b0;
        end

        outstanding_after_wb = outstanding_q - CNT_W'(wb_clear);

        is_tracked_load = sb.issue_is_load && sb.issue_is_reg_write && (sb.issue_rd != 5'd0);

        raw1 = sb.issue_uses_rs1 && (sb.issue_rs1 != 5'd0) && eff_pending[sb.issue_rs1];
        raw2 = sb.issue_uses_rs2 && (sb.issue_rs2 != 5'd0) && eff_pending[sb.issue_rs2];
        waw  = sb.issue_is_reg_write && (sb.issue_rd != 5'd0) && eff_pending[sb.issue_rd];
        full = is_tracked_load && (outstanding_after_wb == CNT_W'(MAX_OUTSTANDING));

        // Flush only withholds acceptance; the stall itself reflects hazards alone.
        stall = sb.issue_valid && (raw1 || raw2 || waw || full);
        fire  = sb.issue_valid && !stall && !sb.flush;
        set   = fire && is_tracked_load;
    end

    // Next pending table and count: clear the written-back register, then set the
    // newly issued load so a same-register set/clear leaves the new load pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_clear) begin
            pending_d[sb.wb_reg] = 1'b0;
        end
        if (set) begin
            pending_d[sb.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        outstanding_d = outstanding_q;
        case ({set, wb_clear})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers with synchronous reset that drops all pending loads.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            pending_q     <= '0;
            outstanding_q <= '0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign sb.issue_stall = stall;
    assign sb.issue_fire  = fire;
    assign pending_mask   = pending_q;
    assign outstanding    = outstanding_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed testbench for load_scoreboard with MAX_OUTSTANDING=4. Inputs are
// driven 1 time unit after the rising edge; combinational outputs are checked
// 1 unit later, registered outputs after the following edge.
module tb_load_scoreboard;

    localparam int MAX_OUT = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic             clk;
    logic             rst;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] outstanding;

    int checks   = 0;
    int failures = 0;

    load_scoreboard_if sb_if ();

    load_scoreboard #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .sb           (sb_if),
        .pending_mask (pending_mask),
        .outstanding  (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Deassert every request input.
    task automatic idle();
        sb_if.flush              = 1'b0;
        sb_if.issue_valid        = 1'b0;
        sb_if.issue_uses_rs1     = 1'b0;
        sb_if.issue_uses_rs2     = 1'b0;
        sb_if.issue_rs1          = 5'd0;
        sb_if.issue_rs2          = 5'd0;
        sb_if.issue_rd           = 5'd0;
        sb_if.issue_is_reg_write = 1'b0;
        sb_if.issue_is_load      = 1'b0;
        sb_if.wb_valid           = 1'b0;
        sb_if.wb_reg             = 5'd0;
    endtask

    // Present a load to rd (no source registers used).
    task automatic issue_load(input logic [4:0] rd);
        sb_if.issue_valid        = 1'b1;
        sb_if.issue_uses_rs1     = 1'b0;
        sb_if.issue_uses_rs2     = 1'b0;
        sb_if.issue_rd           = rd;
        sb_if.issue_is_reg_write = 1'b1;
        sb_if.issue_is_load      = 1'b1;
    endtask

    // Present an ALU op rd <= f(rs1, rs2).
    task automatic issue_alu(input logic u1, input logic [4:0] rs1,
                             input logic u2, input logic [4:0] rs2,
                             input logic [4:0] rd);
        sb_if.issue_valid        = 1'b1;
        sb_if.issue_uses_rs1     = u1;
        sb_if.issue_rs1          = rs1;
        sb_if.issue_uses_rs2     = u2;
        sb_if.issue_rs2          = rs2;
        sb_if.issue_rd           = rd;
        sb_if.issue_is_reg_write = 1'b1;
        sb_if.issue_is_load      = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_reg   = r;
    endtask

    // Advance one clock; leaves time 1 unit after the edge for driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag, input logic stall, input logic fire);
        #1;
        check({tag, "_stall"}, 32'(sb_if.issue_stall), 32'(stall));
        check({tag, "_fire"},  32'(sb_if.issue_fire),  32'(fire));
    endtask

    task automatic check_state(input string tag, input logic [31:0] mask, input int cnt);
        check({tag, "_mask"}, pending_mask, mask);
        check({tag, "_cnt"},  32'(outstanding), 32'(cnt));
    endtask

    // Structural invariant checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("inv_popcount", 32'(outstanding), 32'($countones(pending_mask)));
            check("inv_x0", 32'(pending_mask[0]), 32'd0);
            check("inv_bound", 32'(outstanding <= CNT_W'(MAX_OUT)), 32'd1);
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_state("reset", 32'h0, 0);
        check_comb("reset_idle", 1'b0, 1'b0);

        // RAW on a pending load, resolved by a same-cycle writeback.
        step();
        issue_load(5'd5);
        check_comb("ld5", 1'b0, 1'b1);
        step();
        idle();
        issue_alu(1'b1, 5'd5, 1'b0, 5'd0, 5'd10);
        check_comb("raw5", 1'b1, 1'b0);
        check_state("ld5_after", 32'h20, 1);
        step();
        check_comb("raw5_hold", 1'b1, 1'b0);
        wb(5'd5);
        check_comb("raw5_wb", 1'b0, 1'b1);
        step();
        idle();
        check_state("wb5_after", 32'h0, 0);

        // Load to x0 is never tracked; reading x0 never stalls.
        issue_load(5'd0);
        check_comb("ld_x0", 1'b0, 1'b1);
        step();
        idle();
        check_state("ld_x0_after", 32'h0, 0);
        issue_alu(1'b1, 5'd0, 1'b1, 5'd0, 5'd11);
        check_comb("rd_x0", 1'b0, 1'b1);
        step();
        idle();

        // Fill the table, then free a slot in the same cycle as the fifth load.
        for (int r = 1; r <= 4; r++) begin
            issue_load(5'(r));
            check_comb("fill", 1'b0, 1'b1);
            step();
        end
        idle();
        check_state("full4", 32'h1E, 4);
        issue_load(5'd6);
        check_comb("full_stall", 1'b1, 1'b0);
        wb(5'd1);
        check_comb("full_wb", 1'b0, 1'b1);
        step();
        idle();
        check_state("full_swap", 32'h5C, 4);
        // Full does not block a non-load instruction.
        issue_alu(1'b1, 5'd8, 1'b0, 5'd0, 5'd9);
        check_comb("full_alu", 1'b0, 1'b1);
        step();
        idle();
        wb(5'd2); step();
        wb(5'd3); step();
        wb(5'd4); step();
        wb(5'd6); step();
        idle();
        check_state("drain", 32'h0, 0);

        // WAW on rd=7 resolved by same-cycle writeback; new load stays pending.
        issue_load(5'd7);
        check_comb("ld7", 1'b0, 1'b1);
        step();
        idle();
        issue_load(5'd7);
        check_comb("waw7", 1'b1, 1'b0);
        wb(5'd7);
        check_comb("waw7_wb", 1'b0, 1'b1);
        step();
        idle();
        check_state("waw7_after", 32'h80, 1);
        wb(5'd7);
        step();
        idle();
        check_state("wb7_after", 32'h0, 0);

        // Flush blocks acceptance but keeps pending state.
        issue_load(5'd3);
        step();
        idle();
        check_state("ld3", 32'h8, 1);
        issue_alu(1'b1, 5'd1, 1'b0, 5'd3, 5'd2);
        check_comb("rs2_unused", 1'b0, 1'b1);
        sb_if.flush = 1'b1;
        check_comb("flush", 1'b0, 1'b0);
        step();
        idle();
        check_state("flush_after", 32'h8, 1);
        issue_alu(1'b0, 5'd0, 1'b1, 5'd3, 5'd2);
        check_comb("raw2_3", 1'b1, 1'b0);
        step();
        idle();
        wb(5'd3);
        step();
        idle();
        check_state("wb3_after", 32'h0, 0);

        // Writebacks to non-pending registers and x0 are ignored.
        wb(5'd9);
        step();
        wb(5'd0);
        step();
        idle();
        check_state("wb_ignored", 32'h0, 0);

        // Reset mid-stream with three loads pending, then a late writeback.
        issue_load(5'd8);  step();
        issue_load(5'd9);  step();
        issue_load(5'd10); step();
        idle();
        check_state("three", 32'h700, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_state("mid_reset", 32'h0, 0);
        wb(5'd9);
        step();
        idle();
        check_state("late_wb", 32'h0, 0);
        issue_alu(1'b1, 5'd9, 1'b1, 5'd10, 5'd8);
        check_comb("after_reset_rd", 1'b0, 1'b1);
        step();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Tracks destination registers of in-flight long-latency (load) instructions between decode and writeback.
- Produces a combinational issue stall for the decode stage when a source or destination register of the instruction at decode is still pending.
- Sits beside decode and drives its next-stage stall together with the skid buffer controller.
- Short-latency results are covered by the exec/writeback bypass network; this block handles only results the bypass network cannot supply in time.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of simultaneously pending load destinations (1..31).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; suppresses issue this cycle
- issue_valid  in  1  decode holds a valid instruction
- issue_uses_rs1  in  1  instruction reads rs1
- issue_uses_rs2  in  1  instruction reads rs2
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_is_reg_write  in  1  instruction writes rd
- issue_is_load  in  1  instruction is long-latency (load)
- wb_valid  in  1  load result written back this cycle
- wb_reg  in  5  register written by that load
- issue_stall  out  1  decode must hold (combinational)
- issue_fire  out  1  instruction accepted this cycle (combinational)
- pending_mask  out  32  registered pending bit per register; bit 0 always 0
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  registered count of pending bits

Behaviour:
- Reset (synchronous, rst=1 at posedge): pending_mask=0, outstanding=0.
  - issue_stall and issue_fire are combinational and evaluate to 0 while issue_valid=0.
- wb_clear = wb_valid && wb_reg!=0 && pending_mask[wb_reg].
  - wb_valid for a non-pending register, or for x0, is ignored: no state change.
- eff_pending = pending_mask with bit wb_reg cleared when wb_clear. A same-cycle writeback is visible to the hazard check because the writeback bypass supplies the data.
- Hazards:
  - raw1 = issue_uses_rs1 && issue_rs1!=0 && eff_pending[issue_rs1]; raw2 likewise for rs2.
  - waw = issue_is_reg_write && issue_rd!=0 && eff_pending[issue_rd].
  - full = issue_is_load && issue_is_reg_write && issue_rd!=0 && (outstanding - wb_clear) == MAX_OUTSTANDING.
- issue_stall = issue_valid && (raw1 || raw2 || waw || full). Independent of flush.
- issue_fire = issue_valid && !issue_stall && !flush.
- set = issue_fire && issue_is_load && issue_is_reg_write && issue_rd!=0.
- Next state at posedge (no rst):
  - pending_mask[wb_reg] cleared if wb_clear; pending_mask[issue_rd] set if set.
  - Set wins on the same register. Unreachable except via the same-cycle clear path, where the new load must remain pending.
  - outstanding += set - wb_clear (never wraps). When set and wb_clear occur together, outstanding is unchanged.
- Invariant: outstanding == popcount(pending_mask) <= MAX_OUTSTANDING. Verification asserts this every cycle.
- Flush: pending state is preserved. Loads already past decode are older than the flush point and still write back. Flush only blocks acceptance in its cycle.
- Reset mid-operation: all pending state is dropped. A late wb_valid for a dropped register is ignored.
- Latency: hazard check is zero-cycle combinational. State becomes visible on pending_mask/outstanding one cycle after the triggering event.

Test Plan:
- Reset, then issue load rd=5 (fire=1), next cycle issue add rs1=5 -> issue_stall=1, pending_mask=0x20, outstanding=1; hold until wb_valid wb_reg=5 -> same cycle issue_stall=0, issue_fire=1, next cycle pending_mask=0, outstanding=0.
- Load to x0 -> fire=1, pending_mask stays 0, outstanding stays 0. Subsequent reader of rs1=0 never stalls.
- MAX_OUTSTANDING=4: fire loads rd=1,2,3,4; fifth load rd=6 -> issue_stall=1 (full). Add wb_valid wb_reg=1 in same cycle -> fifth load fires, outstanding stays 4, pending_mask=0x5C.
- Pending rd=7, issue load rd=7 (WAW) -> stall. In the cycle wb_reg=7 arrives -> fires; next cycle pending_mask[7]=1, outstanding=1 (set wins).
- Pending rd=3, flush=1 with a valid non-hazard instruction -> issue_fire=0, issue_stall=0, pending_mask unchanged (0x8); later wb_reg=3 clears it.
- wb_valid wb_reg=9 with nothing pending -> no change. Assert rst mid-stream with 3 pending -> next cycle pending_mask=0, outstanding=0.
